// File: rtl/branch_pc_sequencer.sv
// ---------------------------------------------------------------------------
// branch_pc_sequencer
//
// Per-thread program counter sequencer at the Controller end of the branch
// path. A round-robin slot counter picks one thread per cycle. For that thread
// the next PC is chosen from the restart request, the first-visit start PC,
// an I/O re-issue, the OR-reduced branch target or a plain increment. The
// choice is written back to the thread's PC slot and issued to fetch one cycle
// later.
//
// Ports
//   clock               in   system clock, all state on rising edge
//   reset_n             in   asynchronous, active-low reset
//   jump                in   branch taken for the current slot's thread
//   branch_destination  in   branch target, used only when jump=1
//   IO_ready_previous   in   0 = previous instruction annulled, re-issue it
//   restart             in   force restart_thread's PC to restart_pc
//   restart_thread      in   thread to force
//   restart_pc          in   PC to force
//   PC                  out  registered PC issued to fetch
//   PC_thread           out  thread owning PC
//   PC_valid            out  PC / PC_thread valid this cycle
// ---------------------------------------------------------------------------
module branch_pc_sequencer #(
  parameter int PC_WIDTH          = 10,
  parameter int THREAD_COUNT      = 8,
  parameter int THREAD_ADDR_WIDTH = 3,
  parameter int INITIAL_THREAD    = 0,
  parameter int START_PC          = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         jump,
  input  logic [PC_WIDTH-1:0]          branch_destination,
  input  logic                         IO_ready_previous,
  input  logic                         restart,
  input  logic [THREAD_ADDR_WIDTH-1:0] restart_thread,
  input  logic [PC_WIDTH-1:0]          restart_pc,
  output logic [PC_WIDTH-1:0]          PC,
  output logic [THREAD_ADDR_WIDTH-1:0] PC_thread,
  output logic                         PC_valid
);

  localparam logic [THREAD_ADDR_WIDTH-1:0] LAST_SLOT = THREAD_ADDR_WIDTH'(THREAD_COUNT - 1);

  logic [THREAD_ADDR_WIDTH-1:0] r_slot;
  logic [PC_WIDTH-1:0]          r_pc_mem [THREAD_COUNT];
  logic [THREAD_COUNT-1:0]      r_started;

  logic [THREAD_ADDR_WIDTH-1:0] w_slot_next;
  logic [PC_WIDTH-1:0]          w_cur_pc;
  logic [PC_WIDTH-1:0]          w_next_pc;
  logic                         w_restart_self;
  logic                         w_restart_other;

  // Next-PC select for the thread owning the current slot.
  always_comb begin
    w_cur_pc        = r_pc_mem[r_slot];
    w_restart_self  = restart && (restart_thread == r_slot);
    w_restart_other = restart && (restart_thread != r_slot);
    w_slot_next     = (r_slot == LAST_SLOT) ? '0 : r_slot + 1'b1;

    if (w_restart_self) begin
      w_next_pc = restart_pc;
    end else if (!r_started[r_slot]) begin
      // First visit since reset issues the start PC regardless of inputs,
      // which still describe nothing this thread has executed.
      w_next_pc = w_cur_pc;
    end else if (!IO_ready_previous) begin
      w_next_pc = w_cur_pc;
    end else if (jump) begin
      w_next_pc = branch_destination;
    end else begin
      // Wraps all-ones to zero by truncation.
      w_next_pc = w_cur_pc + PC_WIDTH'(1);
    end
  end

  // NOTE: every register here, including the per-thread PC array, needs a
  // defined post-reset value (threads start from START_PC), so the array sits
  // in the reset branch rather than being inferred as an unreset RAM.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_slot    <= THREAD_ADDR_WIDTH'(INITIAL_THREAD);
      r_started <= '0;
      for (int i = 0; i < THREAD_COUNT; i++) begin
        r_pc_mem[i] <= PC_WIDTH'(START_PC);
      end
      PC        <= '0;
      PC_thread <= '0;
      PC_valid  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every read above on the pre-edge
      // values, so the slot write and the restart write cannot race.
      r_slot             <= w_slot_next;
      r_pc_mem[r_slot]   <= w_next_pc;
      r_started[r_slot]  <= 1'b1;
      // A restart aimed at another thread never shares an index with the
      // slot write, so both updates land in the same cycle.
      if (w_restart_other) begin
        r_pc_mem[restart_thread]  <= restart_pc;
        r_started[restart_thread] <= 1'b1;
      end
      PC        <= w_next_pc;
      PC_thread <= r_slot;
      PC_valid  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_pc_sequencer.sv
// ---------------------------------------------------------------------------
// tb_branch_pc_sequencer
//
// Self-checking bench for branch_pc_sequencer. A per-thread PC array model
// predicts each issued PC; directed scenarios pin the model with literal
// values, then randomized traffic (including mid-run resets) runs against it.
// ---------------------------------------------------------------------------
module tb_branch_pc_sequencer;

  localparam int PC_WIDTH = 10;
  localparam int TC       = 8;
  localparam int TAW      = 3;

  logic                clock;
  logic                reset_n;
  logic                jump;
  logic [PC_WIDTH-1:0] branch_destination;
  logic                IO_ready_previous;
  logic                restart;
  logic [TAW-1:0]      restart_thread;
  logic [PC_WIDTH-1:0] restart_pc;
  logic [PC_WIDTH-1:0] PC;
  logic [TAW-1:0]      PC_thread;
  logic                PC_valid;

  branch_pc_sequencer #(
    .PC_WIDTH(PC_WIDTH), .THREAD_COUNT(TC), .THREAD_ADDR_WIDTH(TAW),
    .INITIAL_THREAD(0), .START_PC(0)
  ) dut (
    .clock(clock), .reset_n(reset_n), .jump(jump),
    .branch_destination(branch_destination),
    .IO_ready_previous(IO_ready_previous), .restart(restart),
    .restart_thread(restart_thread), .restart_pc(restart_pc),
    .PC(PC), .PC_thread(PC_thread), .PC_valid(PC_valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: one PC and one started flag per thread, plus the slot.
  int unsigned m_pc [TC];
  bit          m_started [TC];
  int          m_slot;
  int unsigned exp_pc;
  int          exp_thread;
  bit          exp_valid;

  function automatic void model_reset();
    m_slot = 0;
    for (int i = 0; i < TC; i++) begin
      m_pc[i]      = 0;
      m_started[i] = 1'b0;
    end
    exp_pc     = 0;
    exp_thread = 0;
    exp_valid  = 1'b0;
  endfunction

  function automatic void model_cycle();
    int          t;
    int unsigned nxt;
    t = m_slot;
    if (restart && int'(restart_thread) == t)  nxt = restart_pc;
    else if (!m_started[t])                    nxt = m_pc[t];
    else if (!IO_ready_previous)               nxt = m_pc[t];
    else if (jump)                             nxt = branch_destination;
    else                                       nxt = (m_pc[t] + 1) % (1 << PC_WIDTH);
    if (restart && int'(restart_thread) != t) begin
      m_pc[restart_thread]      = restart_pc;
      m_started[restart_thread] = 1'b1;
    end
    m_pc[t]      = nxt;
    m_started[t] = 1'b1;
    exp_pc       = nxt;
    exp_thread   = t;
    exp_valid    = 1'b1;
    m_slot       = (t + 1) % TC;
  endfunction

  task automatic idle_inputs();
    jump               = 1'b0;
    branch_destination = '0;
    IO_ready_previous  = 1'b1;
    restart            = 1'b0;
    restart_thread     = '0;
    restart_pc         = '0;
  endtask

  // One clock: predict, advance, then compare all outputs 1 time unit later.
  task automatic cycle();
    model_cycle();
    @(posedge clock);
    #1;
    check("pc",     32'(PC),        exp_pc);
    check("thread", 32'(PC_thread), 32'(exp_thread));
    check("valid",  32'(PC_valid),  32'(exp_valid));
  endtask

  task automatic run_to_slot(input int s);
    idle_inputs();
    while (m_slot != s) cycle();
  endtask

  task automatic reset_pass_check(input string tag);
    idle_inputs();
    for (int k = 0; k < 2 * TC; k++) begin
      cycle();
      check({tag, "_pc_lit"},  32'(PC),        (k < TC) ? 32'h0 : 32'h1);
      check({tag, "_thr_lit"}, 32'(PC_thread), 32'(k % TC));
    end
  endtask

  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #1;
    model_reset();
    check({tag, "_pc"},    32'(PC),        32'h0);
    check({tag, "_thr"},   32'(PC_thread), 32'h0);
    check({tag, "_valid"}, 32'(PC_valid),  32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    check("reset_pc",    32'(PC),        32'h0);
    check("reset_thr",   32'(PC_thread), 32'h0);
    check("reset_valid", 32'(PC_valid),  32'h0);
    reset_n = 1'b1;

    // Test 1: two idle passes after release.
    reset_pass_check("t1");

    // Test 2: thread 3 jumps to 0x2A, then increments to 0x2B next pass.
    run_to_slot(3);
    jump = 1'b1; branch_destination = 10'h02A;
    cycle();
    check("t2_jump_lit", 32'(PC), 32'h02A);
    run_to_slot(3);
    cycle();
    check("t2_inc_lit", 32'(PC), 32'h02B);

    // Test 3: thread 5 annulled with a jump present -> re-issue of 2.
    run_to_slot(5);
    IO_ready_previous = 1'b0; jump = 1'b1; branch_destination = 10'h010;
    cycle();
    check("t3_reissue_lit", 32'(PC), 32'h002);
    run_to_slot(5);
    cycle();
    check("t3_inc_lit", 32'(PC), 32'h003);

    // Test 4: thread 2 forced to 0x3FF from slot 6, then wraps to 0.
    restart = 1'b1; restart_thread = 3'd2; restart_pc = 10'h3FF;
    cycle();
    run_to_slot(2);
    cycle();
    check("t4_wrap_lit", 32'(PC), 32'h000);

    // Test 5: restart beats jump on own slot; restart of another thread.
    run_to_slot(4);
    restart = 1'b1; restart_thread = 3'd4; restart_pc = 10'h100;
    jump = 1'b1; branch_destination = 10'h055;
    cycle();
    check("t5_self_lit", 32'(PC), 32'h100);
    run_to_slot(1);
    restart = 1'b1; restart_thread = 3'd6; restart_pc = 10'h100;
    cycle();
    check("t5_other_thr_lit", 32'(PC_thread), 32'h1);
    run_to_slot(6);
    IO_ready_previous = 1'b0;
    cycle();
    check("t5_other_lit", 32'(PC), 32'h100);

    // Test 6: asynchronous reset mid-run; restart held during reset is lost.
    async_reset("t6_async");
    restart = 1'b1; restart_thread = 3'd0; restart_pc = 10'h077;
    repeat (3) @(posedge clock);
    #1;
    check("t6_hold_pc",    32'(PC),       32'h0);
    check("t6_hold_valid", 32'(PC_valid), 32'h0);
    idle_inputs();
    reset_n = 1'b1;
    reset_pass_check("t6");

    // Randomized traffic with occasional mid-run resets.
    for (int n = 0; n < 4000; n++) begin
      if (n % 997 == 500) begin
        async_reset("rnd_async");
        @(posedge clock);
        #1;
        reset_n = 1'b1;
      end
      jump               = 1'($urandom_range(0, 1));
      branch_destination = PC_WIDTH'($urandom);
      if ($urandom_range(0, 7) == 0) branch_destination = PC_WIDTH'(m_pc[m_slot]);
      IO_ready_previous  = ($urandom_range(0, 3) != 0);
      restart            = ($urandom_range(0, 7) == 0);
      restart_thread     = TAW'($urandom);
      restart_pc         = ($urandom_range(0, 3) == 0) ? '1 : PC_WIDTH'($urandom);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
